ocm_s2_arbiter: RTL and testbench
=================================

OCM_S2_ARBITER -- requirements
Module: ocm_s2_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels, range 2..8.
REQ-002 SHALL have parameter DATA_W, default 128: memory data width, a multiple of 8.
REQ-003 SHALL have parameter ADDR_W, default 6: memory word-address width.
REQ-004 SHALL have parameter READ_LAT, default 1: memory read latency in cycles from command to readdata, range 1..3.
REQ-005 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-006 clk_clk  in  1  sole clock; all logic rising-edge.
REQ-007 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-008 ch_req_valid  in  NUM_CH  per-channel request valid.
REQ-009 ch_req_ready  out  NUM_CH  per-channel grant; a request is accepted when valid and ready are both high.
REQ-010 ch_req_write  in  NUM_CH  1 = write, 0 = read.
REQ-011 ch_req_addr  in  NUM_CH*ADDR_W  packed word addresses, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-012 ch_req_wdata  in  NUM_CH*DATA_W  packed write data.
REQ-013 ch_req_be  in  NUM_CH*DATA_W/8  packed byte enables.
REQ-014 ch_rsp_valid  out  NUM_CH  one-cycle read-data-valid pulse to the owning channel.
REQ-015 ch_rsp_rdata  out  DATA_W  read data, shared by all channels, qualified by ch_rsp_valid.
REQ-016 mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable  out  ADDR_W/1/1/DATA_W/DATA_W/8  registered command to the on-chip memory s2 port.
REQ-017 mem_clken  out  1  held high outside reset.
REQ-018 mem_readdata  in  DATA_W  memory read data.

Function
REQ-019 SHALL assert at most one ch_req_ready bit per cycle, and only on a channel whose ch_req_valid is high.
REQ-020 ch_req_ready SHALL be a combinational function of ch_req_valid and the registered priority pointer.
REQ-021 ARB_MODE=0: search SHALL start at pointer; after an accepted request from channel k, pointer SHALL become (k+1) mod NUM_CH, wrapping from NUM_CH-1 to 0; with no acceptance the pointer SHALL hold.
REQ-022 ARB_MODE=1: the lowest-index valid channel SHALL be granted; the pointer SHALL be unused.
REQ-023 An accept in cycle N SHALL drive the mem_* command, with mem_chipselect=1, in cycle N+1; cycles with no accept SHALL drive mem_chipselect=0 and mem_write=0.
REQ-024 A read accepted in cycle N SHALL produce ch_rsp_valid[k]=1 and ch_rsp_rdata=mem_readdata in cycle N+1+READ_LAT.
REQ-025 Writes SHALL produce no response.
REQ-026 A READ_LAT-deep shift register carrying {valid, channel id} SHALL track in-flight reads, allowing back-to-back reads at one per cycle.
REQ-027 ch_rsp_rdata SHALL pass mem_readdata through unregistered.
REQ-028 A write followed by a read of the same address on consecutive accepts SHALL return the new data, relying on memory ordering with no forwarding.
REQ-029 A channel holding ch_req_valid high SHALL keep its request fields stable until accepted; the arbiter SHALL NOT check this.

Reset
REQ-030 While reset_reset_n=0: pointer=0, pipeline valids=0, ch_req_ready=0, ch_rsp_valid=0, mem_chipselect=0, mem_write=0, mem_clken=0; mem_address, mem_writedata and mem_byteenable SHALL be 0.
REQ-031 Reset asserted with reads in flight SHALL discard them; no ch_rsp_valid pulse SHALL appear after reset release for a pre-reset request.
REQ-032 The first grant SHALL be possible in the first cycle after reset release.

Structure
REQ-033 Shared package ocm_pkg SHALL hold the ARB_MODE encodings (ARB_RR, ARB_FIXED) and the function computing channel-id width, clog2 of NUM_CH with a minimum of 1.
REQ-034 The grant logic SHALL be the sub-module ocm_rr_grant (inputs: valid vector, pointer, mode; output: one-hot grant and encoded index); pipeline and command registers stay in ocm_s2_arbiter.

Verification
REQ-035 Single read: channel 2 reads addr 0x05 holding 0xA5 repeated, READ_LAT=1 -> ready[2] in cycle 0, mem_chipselect=1 in cycle 1, rsp_valid=4'b0100 with that data in cycle 2.
REQ-036 Contention, RR: all four valid continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3.
REQ-037 Fixed priority, ARB_MODE=1: channels 1 and 3 valid for 3 cycles -> channel 1 granted all 3 cycles; channel 3 granted only after channel 1 drops valid.
REQ-038 Write then read: channel 0 writes 0x3C to addr 0x3F with be=16'h0001, then channel 1 reads addr 0x3F -> rdata[7:0]=0x3C; no rsp for the write.
REQ-039 Pipelining, READ_LAT=3: 4 back-to-back reads from channels 0..3 -> 4 consecutive rsp pulses to channels 0..3, 4 cycles after each accept.
REQ-040 Reset mid-flight: reset asserted one cycle after a read accept, released 2 cycles later -> ch_rsp_valid stays 0, pointer=0, and the next grant goes to the lowest valid channel.

Source files
------------

// File: rtl/ocm_pkg.sv
// Shared definitions for the on-chip-memory s2 arbiter slice:
// arbitration mode encodings and channel-id sizing.
package ocm_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Width of an encoded channel index; a two-channel arbiter still needs one bit.
  function automatic int ch_id_w(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/ocm_s2_arbiter_if.sv
// Request/response channels plus the s2 memory command port of the arbiter.
interface ocm_s2_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 6
);

  logic [NUM_CH-1:0]          ch_req_valid;
  logic [NUM_CH-1:0]          ch_req_ready;
  logic [NUM_CH-1:0]          ch_req_write;
  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr;
  logic [NUM_CH*DATA_W-1:0]   ch_req_wdata;
  logic [NUM_CH*DATA_W/8-1:0] ch_req_be;
  logic [NUM_CH-1:0]          ch_rsp_valid;
  logic [DATA_W-1:0]          ch_rsp_rdata;
  logic [ADDR_W-1:0]          mem_address;
  logic                       mem_chipselect;
  logic                       mem_write;
  logic [DATA_W-1:0]          mem_writedata;
  logic [DATA_W/8-1:0]        mem_byteenable;
  logic                       mem_clken;
  logic [DATA_W-1:0]          mem_readdata;

  modport slave (
    input  ch_req_valid, ch_req_write, ch_req_addr, ch_req_wdata, ch_req_be, mem_readdata,
    output ch_req_ready, ch_rsp_valid, ch_rsp_rdata,
    output mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken
  );

  modport master (
    output ch_req_valid, ch_req_write, ch_req_addr, ch_req_wdata, ch_req_be, mem_readdata,
    input  ch_req_ready, ch_rsp_valid, ch_rsp_rdata,
    input  mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken
  );

endinterface

// File: rtl/ocm_rr_grant.sv
// Combinational grant selection: round-robin search from a pointer, or
// fixed priority with channel 0 highest when mode is set.
module ocm_rr_grant
  import ocm_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_id_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [CH_W-1:0]   ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  always_comb begin
    logic [CH_W-1:0] start;
    logic [CH_W-1:0] ci;
    logic            found;
    int              c;
    start     = mode ? '0 : ptr;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    ci        = '0;
    // Walk the channels in priority order starting at 'start', wrapping once.
    for (int o = 0; o < NUM_CH; o++) begin
      c = int'(start) + o;
      if (c >= NUM_CH) c = c - NUM_CH;
      ci = CH_W'(c);
      if (!found && valid[ci]) begin
        found       = 1'b1;
        grant[ci]   = 1'b1;
        grant_idx   = ci;
      end
    end
  end

endmodule

// File: rtl/ocm_s2_arbiter.sv
// Arbitrates NUM_CH request channels onto one on-chip-memory s2 port and
// routes read data back to the requesting channel after READ_LAT cycles.
module ocm_s2_arbiter
  import ocm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 6,
  parameter int READ_LAT = 1,
  parameter int ARB_MODE = ARB_RR
) (
  input logic             clk_clk,
  input logic             reset_reset_n,
  ocm_s2_arbiter_if.slave bus
);

  localparam int CH_W = ch_id_w(NUM_CH);
  localparam int BE_W = DATA_W / 8;

  logic [CH_W-1:0]   ptr_q;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic [NUM_CH-1:0] ready;
  logic              accept;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;

  logic              cs_p0;
  logic              wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [BE_W-1:0]   be_p0;
  logic [CH_W-1:0]   ch_p0;
  logic              rd_vld_p0;

  logic [READ_LAT-1:0] vld_p1;
  logic [CH_W-1:0]     ch_p1 [READ_LAT];
  logic [NUM_CH-1:0]   rsp_valid;

  ocm_rr_grant #(.NUM_CH(NUM_CH)) u_grant (
    .valid     (bus.ch_req_valid),
    .ptr       (ptr_q),
    .mode      (ARB_MODE == ARB_FIXED),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // No grant may escape while reset is held, even though the search is combinational.
  assign ready            = grant & {NUM_CH{reset_reset_n}};
  assign accept           = |ready;
  assign bus.ch_req_ready = ready;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_write = bus.ch_req_write[i];
        sel_addr  = bus.ch_req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.ch_req_wdata[i*DATA_W +: DATA_W];
        sel_be    = bus.ch_req_be[i*BE_W +: BE_W];
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ptr_q <= '0;
    end else if (accept && (ARB_MODE == ARB_RR)) begin
      ptr_q <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // ---- stage p0: registered memory command ----
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cs_p0    <= 1'b0;
      wr_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      be_p0    <= '0;
    end else begin
      cs_p0    <= accept;
      wr_p0    <= accept & sel_write;
      addr_p0  <= sel_addr;
      wdata_p0 <= sel_wdata;
      be_p0    <= sel_be;
    end
  end

  assign rd_vld_p0 = cs_p0 & ~wr_p0;

  // ---- stage p1..: in-flight read tracking, one entry per memory latency cycle ----
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vld_p1 <= '0;
    end else begin
      vld_p1[0] <= rd_vld_p0;
      for (int j = 1; j < READ_LAT; j++) vld_p1[j] <= vld_p1[j-1];
    end
  end

  always_ff @(posedge clk_clk) begin
    ch_p0    <= grant_idx;
    ch_p1[0] <= ch_p0;
    for (int j = 1; j < READ_LAT; j++) ch_p1[j] <= ch_p1[j-1];
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (vld_p1[READ_LAT-1] && (ch_p1[READ_LAT-1] == CH_W'(i))) rsp_valid[i] = 1'b1;
    end
  end

  assign bus.ch_rsp_valid   = rsp_valid;
  assign bus.ch_rsp_rdata   = bus.mem_readdata;
  assign bus.mem_address    = addr_p0;
  assign bus.mem_chipselect = cs_p0;
  assign bus.mem_write      = wr_p0;
  assign bus.mem_writedata  = wdata_p0;
  assign bus.mem_byteenable = be_p0;
  assign bus.mem_clken      = reset_reset_n;

endmodule

// File: tb/tb_ocm_s2_arbiter.sv
// Bench for ocm_s2_arbiter: three configurations (RR/LAT1, FIXED/LAT1, RR/LAT3)
// share one stimulus stream; each has its own memory and reference model.
module tb_ocm_s2_arbiter;

  localparam int NC = 4;
  localparam int DW = 128;
  localparam int AW = 6;
  localparam int BW = DW / 8;

  function automatic int mode_of(input int m);
    return (m == 1) ? 1 : 0;
  endfunction

  function automatic int lat_of(input int m);
    return (m == 2) ? 3 : 1;
  endfunction

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] w;
    if (a == 5) return {16{8'hA5}};
    w = 32'(a) * 32'h9E3779B1 + 32'h0F0F1234;
    return {4{w}};
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0]    valid, write;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] wdata;
  logic [NC*BW-1:0] be;

  logic [NC-1:0] rdy  [3];
  logic [NC-1:0] rspv [3];
  logic [DW-1:0] rdat [3];
  logic [DW-1:0] mwd  [3];
  logic [AW-1:0] madr [3];
  logic [BW-1:0] mbe  [3];
  logic          mcs  [3];
  logic          mwr  [3];
  logic          mclk [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = lat_of(g);
    ocm_s2_arbiter_if #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW)) bus ();
    ocm_s2_arbiter #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .READ_LAT(L), .ARB_MODE(mode_of(g)))
      u_dut (.clk_clk(clk), .reset_reset_n(rst_n), .bus(bus));

    logic [DW-1:0] mem   [64];
    logic [DW-1:0] rpipe [3];
    initial for (int a = 0; a < 64; a++) mem[a] = init_word(a);
    always @(posedge clk) begin
      if (bus.mem_chipselect && bus.mem_write)
        for (int b = 0; b < BW; b++)
          if (bus.mem_byteenable[b]) mem[bus.mem_address][b*8 +: 8] = bus.mem_writedata[b*8 +: 8];
      rpipe[0] <= mem[bus.mem_address];
      rpipe[1] <= rpipe[0];
      rpipe[2] <= rpipe[1];
    end
    assign bus.mem_readdata = rpipe[L-1];

    assign bus.ch_req_valid = valid;
    assign bus.ch_req_write = write;
    assign bus.ch_req_addr  = addr;
    assign bus.ch_req_wdata = wdata;
    assign bus.ch_req_be    = be;
    assign rdy[g]  = bus.ch_req_ready;
    assign rspv[g] = bus.ch_rsp_valid;
    assign rdat[g] = bus.ch_rsp_rdata;
    assign mwd[g]  = bus.mem_writedata;
    assign madr[g] = bus.mem_address;
    assign mbe[g]  = bus.mem_byteenable;
    assign mcs[g]  = bus.mem_chipselect;
    assign mwr[g]  = bus.mem_write;
    assign mclk[g] = bus.mem_clken;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, want);
    end
  endtask

  // Reference model state: arbitration pointer, pending command, scheduled responses, memory image.
  int            ptr     [3];
  bit            cmd_cs  [3];
  bit            cmd_wr  [3];
  logic [AW-1:0] cmd_adr [3];
  logic [DW-1:0] cmd_wd  [3];
  logic [BW-1:0] cmd_be  [3];
  bit            sv      [3][8];
  int            sch     [3][8];
  logic [DW-1:0] sdat    [3][8];
  logic [DW-1:0] shadow  [3][64];
  int            cyc = 0;

  task automatic model_cycle(input int m);
    int k, slot, c, s;
    logic [NC-1:0] er, ev;
    bit ecs;
    k = -1;
    if (rst_n) begin
      for (int o = 0; o < NC; o++) begin
        c = ((mode_of(m) != 0 ? 0 : ptr[m]) + o) % NC;
        if (k < 0 && valid[c[1:0]]) k = c;
      end
    end
    er   = (k < 0) ? '0 : (NC'(1) << k);
    slot = cyc % 8;
    ev   = (rst_n && sv[m][slot]) ? (NC'(1) << sch[m][slot]) : '0;
    ecs  = rst_n && cmd_cs[m];
    chk($sformatf("u%0d_ready c%0d", m, cyc), rdy[m], er);
    chk($sformatf("u%0d_rsp_valid c%0d", m, cyc), rspv[m], ev);
    if (ev != 0) chk($sformatf("u%0d_rdata c%0d", m, cyc), rdat[m], sdat[m][slot]);
    chk($sformatf("u%0d_cs c%0d", m, cyc), mcs[m], ecs);
    chk($sformatf("u%0d_wr c%0d", m, cyc), mwr[m], ecs && cmd_wr[m]);
    chk($sformatf("u%0d_clken c%0d", m, cyc), mclk[m], rst_n);
    if (ecs) chk($sformatf("u%0d_addr c%0d", m, cyc), madr[m], cmd_adr[m]);
    if (ecs && cmd_wr[m]) begin
      chk($sformatf("u%0d_wdata c%0d", m, cyc), mwd[m], cmd_wd[m]);
      chk($sformatf("u%0d_be c%0d", m, cyc), mbe[m], cmd_be[m]);
    end
    sv[m][slot] = 1'b0;
    if (!rst_n) begin
      ptr[m] = 0;
      cmd_cs[m] = 1'b0;
      cmd_wr[m] = 1'b0;
      for (int j = 0; j < 8; j++) sv[m][j] = 1'b0;
    end else begin
      if (cmd_cs[m] && cmd_wr[m])
        for (int b = 0; b < BW; b++)
          if (cmd_be[m][b]) shadow[m][cmd_adr[m]][b*8 +: 8] = cmd_wd[m][b*8 +: 8];
      if (k >= 0) begin
        cmd_cs[m]  = 1'b1;
        cmd_wr[m]  = write[k[1:0]];
        cmd_adr[m] = addr[k*AW +: AW];
        cmd_wd[m]  = wdata[k*DW +: DW];
        cmd_be[m]  = be[k*BW +: BW];
        if (!write[k[1:0]]) begin
          s = (cyc + 1 + lat_of(m)) % 8;
          sv[m][s]   = 1'b1;
          sch[m][s]  = k;
          sdat[m][s] = shadow[m][cmd_adr[m]];
        end
        if (mode_of(m) == 0) ptr[m] = (k + 1) % NC;
      end else begin
        cmd_cs[m] = 1'b0;
        cmd_wr[m] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      ptr[m] = 0;
      cmd_cs[m] = 1'b0;
      cmd_wr[m] = 1'b0;
      for (int j = 0; j < 8; j++) sv[m][j] = 1'b0;
      for (int a = 0; a < 64; a++) shadow[m][a] = init_word(a);
    end
    forever begin
      @(negedge clk);
      #3;
      for (int m = 0; m < 3; m++) model_cycle(m);
      cyc++;
    end
  end

  task automatic clear_in();
    valid = '0; write = '0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic set_ch(input int i, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] b);
    valid[i] = 1'b1;
    write[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
    be[i*BW +: BW] = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clear_in();
    end
  endtask

  int exp_ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst_n = 1'b0;
    clear_in();
    valid = '1;
    repeat (2) @(negedge clk);
    #4;
    chk("reset_ready", rdy[0], '0);
    chk("reset_cs", mcs[0], 1'b0);
    chk("reset_clken", mclk[0], 1'b0);
    chk("reset_addr", madr[0], '0);
    chk("reset_rsp", rspv[2], '0);

    // Single read from channel 2, first cycle after reset release.
    @(negedge clk); rst_n = 1'b1; clear_in(); set_ch(2, 1'b0, 6'h05, '0, '0);
    #4 chk("rd1_ready", rdy[0], 4'b0100);
    @(negedge clk); clear_in();
    #4 chk("rd1_cs", mcs[0], 1'b1); chk("rd1_addr", madr[0], 6'h05); chk("rd1_rsp_early", rspv[0], '0);
    @(negedge clk);
    #4 chk("rd1_rsp", rspv[0], 4'b0100); chk("rd1_data", rdat[0], {16{8'hA5}});

    // Round-robin contention from a fresh reset.
    @(negedge clk); rst_n = 1'b0; clear_in();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      clear_in();
      for (int c = 0; c < NC; c++) set_ch(c, 1'b0, AW'(c + 8), '0, '0);
      #4;
      chk($sformatf("rr_order%0d", i), rdy[0], NC'(1) << exp_ord[i]);
      chk($sformatf("fixed_all%0d", i), rdy[1], 4'b0001);
    end
    idle(6);

    // Fixed priority: channel 1 beats channel 3 until it drops.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); clear_in();
      if (i < 3) set_ch(1, 1'b0, 6'h01, '0, '0);
      set_ch(3, 1'b0, 6'h03, '0, '0);
      #4 chk($sformatf("fixed_pri%0d", i), rdy[1], (i < 3) ? 4'b0010 : 4'b1000);
    end
    idle(6);

    // Write then read of the same address on consecutive accepts.
    @(negedge clk); clear_in(); set_ch(0, 1'b1, 6'h3F, DW'(8'h3C), 16'h0001);
    @(negedge clk); clear_in(); set_ch(1, 1'b0, 6'h3F, '0, '0);
    @(negedge clk); clear_in();
    #4 chk("wr_no_rsp", rspv[0], '0);
    @(negedge clk);
    #4 chk("wr_rd_rsp", rspv[0], 4'b0010); chk("wr_rd_byte", rdat[0][7:0], 8'h3C);
    idle(6);

    // Back-to-back reads through the three-cycle-latency instance.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); clear_in();
      if (c < 4) set_ch(c, 1'b0, AW'(10 + c), '0, '0);
      #4 chk($sformatf("pipe_rsp%0d", c), rspv[2], (c < 4) ? '0 : (NC'(1) << (c - 4)));
    end
    idle(6);

    // Reset one cycle after a read accept; the read must vanish and the pointer restart.
    @(negedge clk); clear_in(); set_ch(2, 1'b0, 6'h05, '0, '0);
    #4 chk("rst_mid_accept", rdy[0], 4'b0100);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); clear_in();
      if (c <= 2) rst_n = 1'b0;
      else rst_n = 1'b1;
      if (c == 3) begin
        set_ch(1, 1'b0, 6'h02, '0, '0);
        set_ch(3, 1'b0, 6'h04, '0, '0);
      end
      #4;
      chk($sformatf("rst_mid_rsp0_%0d", c), rspv[0], '0);
      chk($sformatf("rst_mid_rsp2_%0d", c), rspv[2], '0);
      if (c == 3) begin
        chk("rst_mid_grant0", rdy[0], 4'b0010);
        chk("rst_mid_grant2", rdy[2], 4'b0010);
      end
    end
    idle(6);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!rst_n) begin
        if ($urandom_range(0, 2) == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
      end
      valid = NC'($urandom);
      write = NC'($urandom);
      for (int i = 0; i < NC; i++) begin
        addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
        for (int w = 0; w < DW / 32; w++) wdata[i*DW + w*32 +: 32] = $urandom;
        be[i*BW +: BW] = BW'($urandom);
      end
    end
    idle(8);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
